dmux8way16_buf: RTL and testbench

Registered 1-to-8 demultiplexer for 16-bit words, the distribution counterpart of `mux8way16`. One input stream is steered into eight output holding registers `a`..`h`. A word is steered either by an explicit `sel` address or by an internal round-robin pointer. Each output channel has its own valid/ready handshake, so a word is held until its consumer takes it. The block sits between a single producer and eight consumers that `mux8way16` would later gather back together.

---
 rtl/dmux8way16_buf_if.sv | 30 +++
 rtl/dmux8way16_buf.sv | 62 ++++++
 tb/tb_dmux8way16_buf.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmux8way16_buf_if.sv
`default_nettype none
// ============================================================================
// dmux8way16_buf_if : producer/consumer bundle for the 1-to-8 word distributor
// Revision 1.0
// ============================================================================
interface dmux8way16_buf_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       sel;
  logic             rr_mode;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [2:0]       ptr;

  // Environment side: producer plus the eight consumers
  modport master (
    output in_valid, in_data, sel, rr_mode, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, ptr
  );

  modport slave (
    input  in_valid, in_data, sel, rr_mode, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, ptr
  );
endinterface
`default_nettype wire

// File: rtl/dmux8way16_buf.sv
`default_nettype none
// ============================================================================
// dmux8way16_buf : registered 1-to-8 demux with per-channel valid/ready
// Revision 1.0
// ============================================================================
module dmux8way16_buf #(
  parameter int WIDTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dmux8way16_buf_if.slave   bus
);
  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       valid_q, valid_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       w_tgt;
  logic             w_accept;

  assign w_tgt        = bus.rr_mode ? ptr_q : bus.sel;
  // Target may accept when empty or when its consumer drains it this cycle
  assign bus.in_ready = !valid_q[w_tgt] || bus.out_ready[w_tgt];
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 8; i++) begin
      if (w_accept && (w_tgt == 3'(i)))
        valid_d[i] = 1'b1;
      else if (valid_q[i] && bus.out_ready[i])
        valid_d[i] = 1'b0;
    end
  end

  assign ptr_d = (w_accept && bus.rr_mode) ? ptr_q + 3'd1 : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 8'h00;
      ptr_q   <= 3'd0;
      for (int i = 0; i < 8; i++)
        data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < 8; i++)
        if (w_accept && (w_tgt == 3'(i)))
          data_q[i] <= bus.in_data;
    end
  end

  assign bus.a         = data_q[0];
  assign bus.b         = data_q[1];
  assign bus.c         = data_q[2];
  assign bus.d         = data_q[3];
  assign bus.e         = data_q[4];
  assign bus.f         = data_q[5];
  assign bus.g         = data_q[6];
  assign bus.h         = data_q[7];
  assign bus.out_valid = valid_q;
  assign bus.ptr       = ptr_q;
endmodule
`default_nettype wire

// File: tb/tb_dmux8way16_buf.sv
`default_nettype none
// ============================================================================
// tb_dmux8way16_buf : directed self-checking bench for dmux8way16_buf
// Revision 1.0
// ============================================================================
module tb_dmux8way16_buf;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  dmux8way16_buf_if #(.WIDTH(16)) bus ();

  dmux8way16_buf #(.WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_ch(input int i);
    case (i)
      0: return bus.a;
      1: return bus.b;
      2: return bus.c;
      3: return bus.d;
      4: return bus.e;
      5: return bus.f;
      6: return bus.g;
      default: return bus.h;
    endcase
  endfunction

  // Present one word at a falling edge, then check outputs at the next one
  task automatic send(input logic rr, input logic [2:0] s, input logic [15:0] dat);
    bus.rr_mode  = rr;
    bus.sel      = s;
    bus.in_data  = dat;
    bus.in_valid = 1'b1;
    #1;
    chk("send_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sel       = 3'd0;
    bus.rr_mode   = 1'b0;
    bus.out_ready = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("rst_ch%0d", i), 32'(get_ch(i)), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h00);
    chk("rst_ptr", 32'(bus.ptr), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Addressed steering, back-to-back words
    @(negedge clk);
    bus.out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      bus.rr_mode  = 1'b0;
      bus.sel      = 3'(k);
      bus.in_data  = 16'(k + 1);
      bus.in_valid = 1'b1;
      #1;
      chk("addr_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("addr_ch%0d", k), 32'(get_ch(k)), 32'(k + 1));
      chk("addr_out_valid", 32'(bus.out_valid), 32'(8'h01 << k));
      chk("addr_ptr", 32'(bus.ptr), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("addr_idle_valid", 32'(bus.out_valid), 32'h00);

    // Round-robin with wrap
    for (int k = 0; k < 10; k++) begin
      bus.rr_mode  = 1'b1;
      bus.sel      = 3'd6;
      bus.in_data  = 16'hA000 + 16'(k);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_ch%0d", k % 8), 32'(get_ch(k % 8)), 32'(16'hA000 + 16'(k)));
      chk("rr_out_valid", 32'(bus.out_valid), 32'(8'h01 << (k % 8)));
      chk("rr_ptr", 32'(bus.ptr), 32'((k + 1) % 8));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rr_ptr_end", 32'(bus.ptr), 32'd2);

    // Backpressure on channel d
    bus.out_ready = 8'h00;
    send(1'b0, 3'd3, 16'h1234);
    chk("bp_d", 32'(bus.d), 32'h1234);
    chk("bp_valid", 32'(bus.out_valid), 32'h08);
    bus.in_data  = 16'h5678;
    bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_d_held", 32'(bus.d), 32'h1234);
    chk("bp_valid_held", 32'(bus.out_valid), 32'h08);
    chk("bp_ptr_held", 32'(bus.ptr), 32'd2);
    bus.out_ready = 8'h08;
    #1;
    chk("bp_in_ready_drain", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    chk("bp_d_new", 32'(bus.d), 32'h5678);
    chk("bp_valid_kept", 32'(bus.out_valid), 32'h08);
    bus.out_ready = 8'h08;
    @(negedge clk);
    bus.out_ready = 8'h00;
    chk("bp_drained", 32'(bus.out_valid), 32'h00);

    // Drain without reload keeps the data
    send(1'b0, 3'd5, 16'hBEEF);
    chk("dr_f", 32'(bus.f), 32'hBEEF);
    chk("dr_valid", 32'(bus.out_valid), 32'h20);
    bus.out_ready = 8'h20;
    @(negedge clk);
    bus.out_ready = 8'h00;
    chk("dr_valid_clr", 32'(bus.out_valid), 32'h00);
    chk("dr_f_kept", 32'(bus.f), 32'hBEEF);

    // Build out_valid=0F, ptr=4, then reset against an accept
    send(1'b1, 3'd0, 16'h0C0C);
    send(1'b1, 3'd0, 16'h0D0D);
    send(1'b0, 3'd0, 16'h0A0A);
    send(1'b0, 3'd1, 16'h0B0B);
    chk("mr_pre_valid", 32'(bus.out_valid), 32'h0F);
    chk("mr_pre_ptr", 32'(bus.ptr), 32'd4);
    bus.rr_mode  = 1'b1;
    bus.in_data  = 16'hDEAD;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    #1;
    chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.out_valid), 32'h00);
    chk("mr_ptr", 32'(bus.ptr), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("mr_ch%0d", i), 32'(get_ch(i)), 32'h0);
    chk("mr_in_ready_after", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
